// File: rtl/maze_player_ctrl_if.sv
// Bundle between the maze player controller, the button front-end and the level ROM.
// The master side is the controller; the slave side is everything around it.
interface maze_player_ctrl_if #(
    parameter int ROW_W = 3,
    parameter int COL_W = 4,
    parameter int CNT_W = 16
);
    logic             btn_up;
    logic             btn_down;
    logic             btn_left;
    logic             btn_right;
    logic             restart;
    logic [4:0]       num_rows;
    logic [4:0]       num_cols;
    logic [3:0]       walls;
    logic [ROW_W-1:0] row;
    logic [COL_W-1:0] col;
    logic [CNT_W-1:0] move_count;
    logic             bump;
    logic             busy;
    logic             goal_reached;

    modport master (
        input  btn_up, btn_down, btn_left, btn_right, restart,
        input  num_rows, num_cols, walls,
        output row, col, move_count, bump, busy, goal_reached
    );

    modport slave (
        output btn_up, btn_down, btn_left, btn_right, restart,
        output num_rows, num_cols, walls,
        input  row, col, move_count, bump, busy, goal_reached
    );
endinterface

// File: rtl/maze_player_ctrl.sv
// Maze player controller: turns button press edges into wall-checked single-cell moves,
// counts successful moves, applies a post-move lockout and flags arrival at the goal cell.
module maze_player_ctrl #(
    parameter int ROW_W     = 3,
    parameter int COL_W     = 4,
    parameter int START_ROW = 0,
    parameter int START_COL = 0,
    parameter int GOAL_ROW  = 4,
    parameter int GOAL_COL  = 9,
    parameter int LOCK_CYC  = 4,
    parameter int CNT_W     = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    maze_player_ctrl_if.master ctrl_if
);
    localparam int LOCK_W = (LOCK_CYC > 1) ? $clog2(LOCK_CYC) : 1;

    typedef enum logic [1:0] {S_IDLE, S_CHECK, S_LOCK, S_DONE} state_t;
    // Encoded so the direction doubles as the index of its wall bit.
    typedef enum logic [1:0] {DIR_RIGHT = 2'd0, DIR_LEFT = 2'd1, DIR_DOWN = 2'd2, DIR_UP = 2'd3} dir_t;

    state_t            r_state;
    dir_t              r_dir;
    logic [3:0]        r_btnPrev;
    logic [LOCK_W-1:0] r_lockCnt;
    logic [ROW_W-1:0]  r_row;
    logic [COL_W-1:0]  r_col;
    logic [CNT_W-1:0]  r_moveCount;
    logic              r_bump;
    logic              r_busy;
    logic              r_goal;

    logic [3:0] w_btns;
    logic [3:0] w_edge;
    dir_t       w_edgeDir;
    logic [4:0] w_lastRow;
    logic [4:0] w_lastCol;
    logic       w_offGrid;
    logic       w_blocked;
    logic       w_atGoal;

    assign w_btns    = {ctrl_if.btn_up, ctrl_if.btn_down, ctrl_if.btn_left, ctrl_if.btn_right};
    assign w_edge    = w_btns & ~r_btnPrev;
    assign w_lastRow = ctrl_if.num_rows - 5'd1;
    assign w_lastCol = ctrl_if.num_cols - 5'd1;
    assign w_blocked = ctrl_if.walls[r_dir] | w_offGrid;
    assign w_atGoal  = (r_row == ROW_W'(GOAL_ROW)) && (r_col == COL_W'(GOAL_COL));

    always_comb begin
        w_edgeDir = DIR_RIGHT;
        if (w_edge[3])      w_edgeDir = DIR_UP;
        else if (w_edge[2]) w_edgeDir = DIR_DOWN;
        else if (w_edge[1]) w_edgeDir = DIR_LEFT;
    end

    always_comb begin
        w_offGrid = 1'b0;
        case (r_dir)
            DIR_UP:    w_offGrid = (r_row == '0);
            DIR_DOWN:  w_offGrid = (5'(r_row) >= w_lastRow);
            DIR_LEFT:  w_offGrid = (r_col == '0);
            DIR_RIGHT: w_offGrid = (5'(r_col) >= w_lastCol);
            default:   w_offGrid = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_dir       <= DIR_RIGHT;
            r_btnPrev   <= '0;
            r_lockCnt   <= '0;
            r_row       <= ROW_W'(START_ROW);
            r_col       <= COL_W'(START_COL);
            r_moveCount <= '0;
            r_bump      <= 1'b0;
            r_busy      <= 1'b0;
            r_goal      <= 1'b0;
        end else begin
            r_btnPrev <= w_btns;
            if (ctrl_if.restart) begin
                r_state     <= S_IDLE;
                r_row       <= ROW_W'(START_ROW);
                r_col       <= COL_W'(START_COL);
                r_moveCount <= '0;
                r_bump      <= 1'b0;
                r_busy      <= 1'b0;
                r_goal      <= 1'b0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (|w_edge) begin
                            r_dir   <= w_edgeDir;
                            r_state <= S_CHECK;
                            r_busy  <= 1'b1;
                        end
                    end
                    S_CHECK: begin
                        if (w_blocked) begin
                            r_bump <= 1'b1;
                        end else begin
                            case (r_dir)
                                DIR_UP:    r_row <= r_row - ROW_W'(1);
                                DIR_DOWN:  r_row <= r_row + ROW_W'(1);
                                DIR_LEFT:  r_col <= r_col - COL_W'(1);
                                default:   r_col <= r_col + COL_W'(1);
                            endcase
                            if (r_moveCount != '1) begin
                                r_moveCount <= r_moveCount + CNT_W'(1);
                            end
                        end
                        r_lockCnt <= LOCK_W'(LOCK_CYC - 1);
                        r_state   <= S_LOCK;
                    end
                    S_LOCK: begin
                        r_bump <= 1'b0;
                        if (r_lockCnt == '0) begin
                            r_busy <= 1'b0;
                            if (w_atGoal) begin
                                r_state <= S_DONE;
                                r_goal  <= 1'b1;
                            end else begin
                                r_state <= S_IDLE;
                            end
                        end else begin
                            r_lockCnt <= r_lockCnt - LOCK_W'(1);
                        end
                    end
                    S_DONE: begin
                        r_state <= S_DONE;
                    end
                    default: begin
                        r_state <= S_IDLE;
                    end
                endcase
            end
        end
    end

    assign ctrl_if.row          = r_row;
    assign ctrl_if.col          = r_col;
    assign ctrl_if.move_count   = r_moveCount;
    assign ctrl_if.bump         = r_bump;
    assign ctrl_if.busy         = r_busy;
    assign ctrl_if.goal_reached = r_goal;
endmodule

// File: tb/tb_maze_player_ctrl.sv
// Self-checking bench for maze_player_ctrl: directed scenarios plus randomized moves over a
// random wall map, all compared against a cell-level model of the maze rules.
module tb_maze_player_ctrl;
    localparam int ROW_W    = 3;
    localparam int COL_W    = 4;
    localparam int CNT_W    = 16;
    localparam int GOAL_ROW = 4;
    localparam int GOAL_COL = 9;
    localparam int LOCK_CYC = 4;
    localparam int NUM_ROWS = 5;
    localparam int NUM_COLS = 10;

    logic clk;
    logic rst_n;
    int   nChecks;
    int   nErrors;

    logic [3:0] wallMap [0:7][0:15];

    int mRow, mCol, mCount;
    bit mDone;
    int expBump, expBusy;
    int bumpCycles, busyCycles;

    maze_player_ctrl_if #(.ROW_W(ROW_W), .COL_W(COL_W), .CNT_W(CNT_W)) bus ();

    maze_player_ctrl #(
        .ROW_W(ROW_W), .COL_W(COL_W), .START_ROW(0), .START_COL(0),
        .GOAL_ROW(GOAL_ROW), .GOAL_COL(GOAL_COL), .LOCK_CYC(LOCK_CYC), .CNT_W(CNT_W)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .ctrl_if(bus.master)
    );

    // The level ROM: combinational lookup addressed by the player position.
    assign bus.walls    = wallMap[bus.row][bus.col];
    assign bus.num_rows = 5'(NUM_ROWS);
    assign bus.num_cols = 5'(NUM_COLS);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic setBtns(input logic [3:0] mask);
        bus.btn_up    = mask[3];
        bus.btn_down  = mask[2];
        bus.btn_left  = mask[1];
        bus.btn_right = mask[0];
    endtask

    task automatic fillMap(input logic [3:0] value);
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 16; c++)
                wallMap[r][c] = value;
    endtask

    task automatic resetModel();
        mRow = 0; mCol = 0; mCount = 0; mDone = 0;
    endtask

    // Cell-level maze rules: highest-priority pressed direction, wall or grid edge blocks.
    task automatic modelMove(input logic [3:0] mask);
        int d;
        bit blocked;
        expBump = 0;
        expBusy = 0;
        if (mDone || mask == 4'd0) return;
        if (mask[3]) d = 3; else if (mask[2]) d = 2; else if (mask[1]) d = 1; else d = 0;
        blocked = wallMap[mRow][mCol][d];
        case (d)
            3: if (mRow == 0) blocked = 1;
            2: if (mRow == NUM_ROWS - 1) blocked = 1;
            1: if (mCol == 0) blocked = 1;
            default: if (mCol == NUM_COLS - 1) blocked = 1;
        endcase
        expBusy = LOCK_CYC + 1;
        if (blocked) begin
            expBump = 1;
        end else begin
            case (d)
                3: mRow--;
                2: mRow++;
                1: mCol--;
                default: mCol++;
            endcase
            mCount++;
        end
        if (mRow == GOAL_ROW && mCol == GOAL_COL) mDone = 1;
    endtask

    // Pulses the given buttons for one cycle and watches bump/busy until the lockout is over.
    task automatic applyStimulus(input logic [3:0] mask);
        modelMove(mask);
        bumpCycles = 0;
        busyCycles = 0;
        @(negedge clk);
        setBtns(mask);
        for (int i = 0; i < LOCK_CYC + 4; i++) begin
            @(negedge clk);
            if (i == 0) setBtns(4'd0);
            if (bus.bump) bumpCycles++;
            if (bus.busy) busyCycles++;
        end
    endtask

    task automatic doRestart();
        @(negedge clk);
        bus.restart = 1'b1;
        @(negedge clk);
        bus.restart = 1'b0;
        resetModel();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #7;
        nChecks++; if (bus.row !== 3'd0) begin nErrors++; $display("[TB] FAIL reset_row: got %0d expected 0", bus.row); end
        nChecks++; if (bus.col !== 4'd0) begin nErrors++; $display("[TB] FAIL reset_col: got %0d expected 0", bus.col); end
        nChecks++; if (bus.move_count !== 16'd0) begin nErrors++; $display("[TB] FAIL reset_count: got %0d expected 0", bus.move_count); end
        nChecks++; if ({bus.bump, bus.busy, bus.goal_reached} !== 3'b000) begin nErrors++; $display("[TB] FAIL reset_flags: got %b expected 000", {bus.bump, bus.busy, bus.goal_reached}); end
        @(negedge clk);
        rst_n = 1'b1;
        resetModel();
        @(negedge clk);
    endtask

    task automatic test_open_right();
        fillMap(4'd0);
        wallMap[0][0] = 4'b1110;
        doRestart();
        modelMove(4'b0001);
        @(negedge clk);
        setBtns(4'b0001);
        @(negedge clk);
        setBtns(4'd0);
        nChecks++; if (bus.col !== 4'd0) begin nErrors++; $display("[TB] FAIL right_early_col: got %0d expected 0", bus.col); end
        busyCycles = bus.busy ? 1 : 0;
        @(negedge clk);
        nChecks++; if (bus.row !== 3'(mRow) || bus.col !== 4'(mCol)) begin nErrors++; $display("[TB] FAIL right_pos: got (%0d,%0d) expected (%0d,%0d)", bus.row, bus.col, mRow, mCol); end
        if (bus.busy) busyCycles++;
        repeat (LOCK_CYC + 2) begin
            @(negedge clk);
            if (bus.busy) busyCycles++;
        end
        nChecks++; if (busyCycles != LOCK_CYC + 1) begin nErrors++; $display("[TB] FAIL right_busy: got %0d expected %0d", busyCycles, LOCK_CYC + 1); end
        nChecks++; if (bus.move_count !== 16'(mCount)) begin nErrors++; $display("[TB] FAIL right_count: got %0d expected %0d", bus.move_count, mCount); end
    endtask

    task automatic test_wall_block();
        fillMap(4'd0);
        wallMap[0][0] = 4'b1110;
        doRestart();
        applyStimulus(4'b0100);
        nChecks++; if (bus.row !== 3'd0 || bus.col !== 4'd0) begin nErrors++; $display("[TB] FAIL wall_pos: got (%0d,%0d) expected (0,0)", bus.row, bus.col); end
        nChecks++; if (bumpCycles != 1) begin nErrors++; $display("[TB] FAIL wall_bump: got %0d cycles expected 1", bumpCycles); end
        nChecks++; if (bus.move_count !== 16'd0) begin nErrors++; $display("[TB] FAIL wall_count: got %0d expected 0", bus.move_count); end
    endtask

    task automatic test_edge_block();
        int bumps;
        fillMap(4'd0);
        doRestart();
        applyStimulus(4'b1000);
        bumps = bumpCycles;
        applyStimulus(4'b0010);
        bumps += bumpCycles;
        nChecks++; if (bumps != 2) begin nErrors++; $display("[TB] FAIL edge_bumps: got %0d expected 2", bumps); end
        nChecks++; if (bus.row !== 3'd0 || bus.col !== 4'd0) begin nErrors++; $display("[TB] FAIL edge_pos: got (%0d,%0d) expected (0,0)", bus.row, bus.col); end
    endtask

    task automatic test_simultaneous();
        fillMap(4'd0);
        doRestart();
        applyStimulus(4'b0100);
        applyStimulus(4'b0100);
        applyStimulus(4'b0001);
        applyStimulus(4'b0001);
        applyStimulus(4'b1001);
        nChecks++; if (bus.row !== 3'd1 || bus.col !== 4'd2) begin nErrors++; $display("[TB] FAIL simul_pos: got (%0d,%0d) expected (1,2)", bus.row, bus.col); end
        nChecks++; if (bus.move_count !== 16'd5) begin nErrors++; $display("[TB] FAIL simul_count: got %0d expected 5", bus.move_count); end
    endtask

    task automatic test_held_lockout();
        fillMap(4'd0);
        doRestart();
        @(negedge clk);
        setBtns(4'b0001);
        repeat (20) @(negedge clk);
        setBtns(4'd0);
        repeat (3) @(negedge clk);
        nChecks++; if (bus.col !== 4'd1 || bus.move_count !== 16'd1) begin nErrors++; $display("[TB] FAIL held: got col %0d count %0d expected col 1 count 1", bus.col, bus.move_count); end
        @(negedge clk);
        setBtns(4'b0001);
        @(negedge clk);
        setBtns(4'd0);
        @(negedge clk);
        setBtns(4'b0001);
        @(negedge clk);
        setBtns(4'd0);
        repeat (LOCK_CYC + 3) @(negedge clk);
        nChecks++; if (bus.col !== 4'd2 || bus.move_count !== 16'd2) begin nErrors++; $display("[TB] FAIL lockout: got col %0d count %0d expected col 2 count 2", bus.col, bus.move_count); end
    endtask

    task automatic test_random();
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 16; c++)
                wallMap[r][c] = 4'($urandom_range(0, 15));
        doRestart();
        for (int n = 0; n < 40; n++) begin
            applyStimulus(4'($urandom_range(0, 15)));
            nChecks++;
            if (bus.row !== 3'(mRow) || bus.col !== 4'(mCol) || bus.move_count !== 16'(mCount)
                || bumpCycles != expBump || busyCycles != expBusy || bus.goal_reached !== mDone) begin
                nErrors++;
                $display("[TB] FAIL random_%0d: got (%0d,%0d) cnt %0d bump %0d busy %0d goal %0b expected (%0d,%0d) cnt %0d bump %0d busy %0d goal %0b",
                         n, bus.row, bus.col, bus.move_count, bumpCycles, busyCycles, bus.goal_reached,
                         mRow, mCol, mCount, expBump, expBusy, mDone);
            end
            if (mDone) doRestart();
        end
    endtask

    task automatic test_goal_restart();
        fillMap(4'd0);
        doRestart();
        repeat (9) applyStimulus(4'b0001);
        repeat (4) applyStimulus(4'b0100);
        nChecks++; if (bus.goal_reached !== 1'b1) begin nErrors++; $display("[TB] FAIL goal_flag: got %b expected 1", bus.goal_reached); end
        applyStimulus(4'b1000);
        nChecks++; if (bus.row !== 3'd4 || bus.col !== 4'd9 || bus.move_count !== 16'd13 || busyCycles != 0) begin nErrors++; $display("[TB] FAIL goal_hold: got (%0d,%0d) cnt %0d busy %0d expected (4,9) cnt 13 busy 0", bus.row, bus.col, bus.move_count, busyCycles); end
        doRestart();
        nChecks++; if (bus.row !== 3'd0 || bus.col !== 4'd0 || bus.move_count !== 16'd0 || bus.goal_reached !== 1'b0) begin nErrors++; $display("[TB] FAIL restart: got (%0d,%0d) cnt %0d goal %b expected (0,0) cnt 0 goal 0", bus.row, bus.col, bus.move_count, bus.goal_reached); end
    endtask

    task automatic test_async_reset();
        fillMap(4'd0);
        doRestart();
        applyStimulus(4'b0001);
        @(negedge clk);
        setBtns(4'b0001);
        @(posedge clk);
        #2;
        nChecks++; if (bus.busy !== 1'b1) begin nErrors++; $display("[TB] FAIL abort_busy: got %b expected 1", bus.busy); end
        rst_n = 1'b0;
        #1;
        nChecks++; if (bus.row !== 3'd0 || bus.col !== 4'd0 || bus.move_count !== 16'd0 || {bus.bump, bus.busy, bus.goal_reached} !== 3'b000) begin nErrors++; $display("[TB] FAIL abort_clear: got (%0d,%0d) cnt %0d flags %b expected (0,0) cnt 0 flags 000", bus.row, bus.col, bus.move_count, {bus.bump, bus.busy, bus.goal_reached}); end
        setBtns(4'd0);
        @(negedge clk);
        rst_n = 1'b1;
        resetModel();
    endtask

    initial begin
        nChecks = 0;
        nErrors = 0;
        bus.restart = 1'b0;
        setBtns(4'd0);
        fillMap(4'd0);
        resetModel();
        test_reset();
        test_open_right();
        test_wall_block();
        test_edge_block();
        test_simultaneous();
        test_held_lockout();
        test_random();
        test_goal_restart();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
        $finish;
    end
endmodule
